// File: rtl/tetris_button_decoder.sv
// Tetris button decoder: NES button levels -> one-cycle game command pulses.
// Optional input debounce when TETRIS_BUTTON_DEBOUNCE_EN is defined.
module tetris_button_decoder #(
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 6,
  parameter int CNT_W     = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_buttons,
  input  logic       i_buttons_valid,
  output logic       o_move_left,
  output logic       o_move_right,
  output logic       o_soft_drop,
  output logic       o_hard_drop,
  output logic       o_rotate_cw,
  output logic       o_rotate_ccw,
  output logic       o_pause_toggle,
  output logic       o_select_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } das_state_t;

  localparam logic [CNT_W-1:0] LP_DLY_TC  = CNT_W'(DAS_DELAY - 2);
  localparam logic [CNT_W-1:0] LP_RATE_TC = CNT_W'(DAS_RATE - 1);

  logic [7:0]       r_prev;
  logic [7:0]       w_cur;
  logic [7:0]       w_rise;

  das_state_t       r_h_state;
  das_state_t       w_h_state_nx;
  logic             r_dir;
  logic             w_dir_nx;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] w_h_cnt_nx;
  logic             w_h_pulse;

  das_state_t       r_d_state;
  das_state_t       w_d_state_nx;
  logic [CNT_W-1:0] r_d_cnt;
  logic [CNT_W-1:0] w_d_cnt_nx;
  logic             w_d_pulse;

  logic             w_l;
  logic             w_r;
  logic             w_dn;

`ifdef TETRIS_BUTTON_DEBOUNCE_EN
  logic [7:0] r_raw;
  logic [7:0] w_eq;

  // A bit is accepted only after two identical consecutive samples;
  // otherwise the previously accepted level (r_prev) is kept.
  assign w_eq  = ~(i_buttons ^ r_raw);
  assign w_cur = (i_buttons & w_eq) | (r_prev & ~w_eq);

  // Remember the last raw sample for the stability comparison
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_raw <= 8'h00;
    end else if (i_buttons_valid) begin
      r_raw <= i_buttons;
    end
  end
`else
  assign w_cur = i_buttons;
`endif

  assign w_rise = w_cur & ~r_prev;
  assign w_l    = w_cur[6];
  assign w_r    = w_cur[7];
  assign w_dn   = w_cur[5];

  // Previous accepted vector for edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= 8'h00;
    end else if (i_buttons_valid) begin
      r_prev <= w_cur;
    end
  end

  // Horizontal DAS state register, advances once per strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h_state <= S_IDLE;
      r_dir     <= 1'b0;
      r_h_cnt   <= '0;
    end else if (i_buttons_valid) begin
      r_h_state <= w_h_state_nx;
      r_dir     <= w_dir_nx;
      r_h_cnt   <= w_h_cnt_nx;
    end
  end

  // Horizontal DAS next state; dir 1 = right, 0 = left
  always_comb begin
    w_h_state_nx = r_h_state;
    w_dir_nx     = r_dir;
    w_h_cnt_nx   = r_h_cnt;
    w_h_pulse    = 1'b0;
    if (w_l == w_r) begin
      w_h_state_nx = S_IDLE;
      w_h_cnt_nx   = '0;
    end else if (r_h_state == S_IDLE || w_r != r_dir) begin
      w_h_pulse    = 1'b1;
      w_dir_nx     = w_r;
      w_h_cnt_nx   = '0;
      w_h_state_nx = S_DELAY;
    end else if (r_h_state == S_DELAY) begin
      if (r_h_cnt == LP_DLY_TC) begin
        w_h_pulse    = 1'b1;
        w_h_cnt_nx   = '0;
        w_h_state_nx = S_REPEAT;
      end else begin
        w_h_cnt_nx = r_h_cnt + 1'b1;
      end
    end else begin
      if (r_h_cnt == LP_RATE_TC) begin
        w_h_pulse  = 1'b1;
        w_h_cnt_nx = '0;
      end else begin
        w_h_cnt_nx = r_h_cnt + 1'b1;
      end
    end
  end

  // Down DAS state register, advances once per strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_d_state <= S_IDLE;
      r_d_cnt   <= '0;
    end else if (i_buttons_valid) begin
      r_d_state <= w_d_state_nx;
      r_d_cnt   <= w_d_cnt_nx;
    end
  end

  // Down DAS next state, same timing rules as horizontal
  always_comb begin
    w_d_state_nx = r_d_state;
    w_d_cnt_nx   = r_d_cnt;
    w_d_pulse    = 1'b0;
    unique case (r_d_state)
      S_IDLE: begin
        if (w_dn) begin
          w_d_pulse    = 1'b1;
          w_d_cnt_nx   = '0;
          w_d_state_nx = S_DELAY;
        end
      end
      S_DELAY: begin
        if (!w_dn) begin
          w_d_state_nx = S_IDLE;
          w_d_cnt_nx   = '0;
        end else if (r_d_cnt == LP_DLY_TC) begin
          w_d_pulse    = 1'b1;
          w_d_cnt_nx   = '0;
          w_d_state_nx = S_REPEAT;
        end else begin
          w_d_cnt_nx = r_d_cnt + 1'b1;
        end
      end
      S_REPEAT: begin
        if (!w_dn) begin
          w_d_state_nx = S_IDLE;
          w_d_cnt_nx   = '0;
        end else if (r_d_cnt == LP_RATE_TC) begin
          w_d_pulse  = 1'b1;
          w_d_cnt_nx = '0;
        end else begin
          w_d_cnt_nx = r_d_cnt + 1'b1;
        end
      end
      default: begin
        w_d_state_nx = S_IDLE;
        w_d_cnt_nx   = '0;
      end
    endcase
  end

  // Registered one-cycle command pulses, zero without a strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_move_left    <= 1'b0;
      o_move_right   <= 1'b0;
      o_soft_drop    <= 1'b0;
      o_hard_drop    <= 1'b0;
      o_rotate_cw    <= 1'b0;
      o_rotate_ccw   <= 1'b0;
      o_pause_toggle <= 1'b0;
      o_select_pulse <= 1'b0;
    end else if (i_buttons_valid) begin
      o_move_left    <= w_h_pulse & ~w_dir_nx;
      o_move_right   <= w_h_pulse & w_dir_nx;
      o_soft_drop    <= w_d_pulse;
      o_hard_drop    <= w_rise[4];
      o_rotate_cw    <= w_rise[0];
      o_rotate_ccw   <= w_rise[1];
      o_pause_toggle <= w_rise[3];
      o_select_pulse <= w_rise[2];
    end else begin
      o_move_left    <= 1'b0;
      o_move_right   <= 1'b0;
      o_soft_drop    <= 1'b0;
      o_hard_drop    <= 1'b0;
      o_rotate_cw    <= 1'b0;
      o_rotate_ccw   <= 1'b0;
      o_pause_toggle <= 1'b0;
      o_select_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tetris_button_decoder.sv
// Scoreboard testbench for tetris_button_decoder (default build,
// glitch case also covers TETRIS_BUTTON_DEBOUNCE_EN).
module tb_tetris_button_decoder;

  // output vector bit positions
  localparam logic [7:0] LF  = 8'h01;
  localparam logic [7:0] RT  = 8'h02;
  localparam logic [7:0] SD  = 8'h04;
  localparam logic [7:0] HD  = 8'h08;
  localparam logic [7:0] CW  = 8'h10;
  localparam logic [7:0] CCW = 8'h20;
  localparam logic [7:0] PS  = 8'h40;
  localparam logic [7:0] SL  = 8'h80;

  // button bit positions
  localparam logic [7:0] BA  = 8'h01;
  localparam logic [7:0] BB  = 8'h02;
  localparam logic [7:0] BSE = 8'h04;
  localparam logic [7:0] BST = 8'h08;
  localparam logic [7:0] BUP = 8'h10;
  localparam logic [7:0] BDN = 8'h20;
  localparam logic [7:0] BL  = 8'h40;
  localparam logic [7:0] BR  = 8'h80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic       valid = 1'b0;
  logic       mv_l, mv_r, sdrop, hdrop, rcw, rccw, pse, sel;
  logic [7:0] outv;

  int         nchk = 0;
  int         npass = 0;
  logic [7:0] expq[$];
  string      nameq[$];

  always #10 clk = ~clk;

  tetris_button_decoder dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_buttons       (buttons),
    .i_buttons_valid (valid),
    .o_move_left     (mv_l),
    .o_move_right    (mv_r),
    .o_soft_drop     (sdrop),
    .o_hard_drop     (hdrop),
    .o_rotate_cw     (rcw),
    .o_rotate_ccw    (rccw),
    .o_pause_toggle  (pse),
    .o_select_pulse  (sel)
  );

  assign outv = {sel, pse, rccw, rcw, hdrop, sdrop, mv_r, mv_l};

  // monitor: accepted strobe -> pop and compare; otherwise outputs must be 0
  initial begin
    logic       v;
    logic [7:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      v = valid && !reset;
      #1;
      nchk++;
      if (v) begin
        if (expq.size() == 0) begin
          $display("FAIL underflow: got %h, required a queued expectation",
                   outv);
        end else begin
          e  = expq.pop_front();
          nm = nameq.pop_front();
          if (outv === e) npass++;
          else $display("FAIL %s: got %h, required %h", nm, outv, e);
        end
      end else begin
        if (outv === 8'h00) npass++;
        else $display("FAIL idle_zero: got %h, required 00 (t=%0t)",
                      outv, $time);
      end
    end
  end

  task automatic strobe(input logic [7:0] b, input logic [7:0] e,
                        input string nm);
    @(negedge clk);
    buttons = b;
    valid   = 1'b1;
    expq.push_back(e);
    nameq.push_back(nm);
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] e;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // A held 5 strobes -> single rotate_cw
    for (int s = 1; s <= 5; s++)
      strobe(BA, (s == 1) ? CW : 8'h00, $sformatf("holdA_%0d", s));
    strobe(8'h00, 8'h00, "relA");

    // B + Select + Start together, then held
    strobe(BB | BSE | BST, CCW | SL | PS, "edges_1");
    strobe(BB | BSE | BST, 8'h00, "edges_2");
    strobe(8'h00, 8'h00, "edges_rel");

    // Left DAS: pulses at 1, 16, 22, 28
    for (int s = 1; s <= 30; s++) begin
      e = (s == 1 || s == 16 || s == 22 || s == 28) ? LF : 8'h00;
      strobe(BL, e, $sformatf("dasL_%0d", s));
    end
    for (int s = 31; s <= 33; s++)
      strobe(8'h00, 8'h00, $sformatf("dasL_rel_%0d", s));

    // Left, then Left+Right, then Right
    for (int s = 1; s <= 27; s++) begin
      if (s <= 5)
        strobe(BL, (s == 1) ? LF : 8'h00, $sformatf("lr_%0d", s));
      else if (s <= 10)
        strobe(BL | BR, 8'h00, $sformatf("lr_%0d", s));
      else
        strobe(BR, (s == 11 || s == 26) ? RT : 8'h00,
               $sformatf("lr_%0d", s));
    end
    strobe(8'h00, 8'h00, "lr_rel");

    // direct Left -> Right switch re-pulses immediately
    strobe(BL, LF, "sw_1");
    strobe(BL, 8'h00, "sw_2");
    strobe(BR, RT, "sw_3");
    strobe(BL, LF, "sw_4");
    strobe(8'h00, 8'h00, "sw_rel");

    // Down + Right, Up added on strobe 3
    strobe(BDN | BR, SD | RT, "dr_1");
    strobe(BDN | BR, 8'h00, "dr_2");
    strobe(BDN | BR | BUP, HD, "dr_3");
    strobe(BDN | BR | BUP, 8'h00, "dr_4");
    strobe(BDN | BR | BUP, 8'h00, "dr_5");
    strobe(8'h00, 8'h00, "dr_rel");

    // Right into REPEAT, reset mid-hold, strobe ignored during reset
    for (int s = 1; s <= 18; s++)
      strobe(BR, (s == 1 || s == 16) ? RT : 8'h00,
             $sformatf("rst_pre_%0d", s));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int s = 1; s <= 17; s++)
      strobe(BR, (s == 1 || s == 16) ? RT : 8'h00,
             $sformatf("rst_post_%0d", s));
    strobe(8'h00, 8'h00, "rst_rel");

    // Start glitch and two-strobe press
    for (int s = 1; s <= 9; s++) begin
      logic [7:0] b;
      b = (s == 4 || s == 6 || s == 7) ? BST : 8'h00;
`ifdef TETRIS_BUTTON_DEBOUNCE_EN
      e = (s == 7) ? PS : 8'h00;
`else
      e = (s == 4 || s == 6) ? PS : 8'h00;
`endif
      strobe(b, e, $sformatf("glitch_%0d", s));
    end

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 100 && expq.size() != 0; i++) @(negedge clk);
    nchk++;
    if (expq.size() == 0) npass++;
    else $display("FAIL drain: got %0d pending, required 0", expq.size());
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/tetris_button_decoder.md
Name: tetris_button_decoder

Overview:
- Sits directly downstream of the NES controller reader. Consumes the 8-bit parallel button vector it produces once per poll.
- Converts raw held/released levels into one-cycle game command pulses for the Tetris game logic.
- Left/Right/Down have delayed auto-shift (DAS) auto-repeat. Rotate, hard drop, pause and select are edge-only.
- All timing counts poll strobes (buttons_valid), not clk cycles.

Parameters:
- DAS_DELAY, 16, held strobes from the first move pulse to the first repeat pulse (2..2^CNT_W-1).
- DAS_RATE, 6, held strobes between repeat pulses (1..2^CNT_W-1).
- CNT_W, 5, width of the DAS counters.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- buttons  in  8  active-high pressed; bit0=A, bit1=B, bit2=Select, bit3=Start, bit4=Up, bit5=Down, bit6=Left, bit7=Right
- buttons_valid  in  1  one-cycle strobe; buttons is sampled only when this is high
- move_left  out  1  one-cycle pulse
- move_right  out  1  one-cycle pulse
- soft_drop  out  1  one-cycle pulse (Down, auto-repeat)
- hard_drop  out  1  one-cycle pulse (Up, rising edge)
- rotate_cw  out  1  one-cycle pulse (A, rising edge)
- rotate_ccw  out  1  one-cycle pulse (B, rising edge)
- pause_toggle  out  1  one-cycle pulse (Start, rising edge)
- select_pulse  out  1  one-cycle pulse (Select, rising edge)

Behaviour:
- Clocking and reset:
  - Single clock domain; every output is registered.
  - Reset: all outputs 0, prev vector 0, both FSMs IDLE, counters 0.
  - buttons_valid is ignored while reset is high.
  - A button still held after reset is treated as a new press on the first strobe.
- Sampling and pulses:
  - cur = accepted vector. prev updates to cur on every strobe.
  - rise = cur & ~prev.
  - Latency: a pulse asserts in the cycle after the strobe that caused it and lasts exactly one cycle.
  - With no strobe, all outputs are 0.
- Edge-only outputs: rotate_cw = rise[0], rotate_ccw = rise[1], select_pulse = rise[2], pause_toggle = rise[3], hard_drop = rise[4].
- Horizontal FSM (IDLE, DELAY, REPEAT; registers dir, cnt). Evaluated on each strobe with L = cur[6], R = cur[7]:
  - L and R both 0, or both 1: go to IDLE, cnt <= 0, no pulse. Holding both never moves.
  - Exactly one of L/R set, and state is IDLE or the set one differs from dir: pulse that direction, dir <= it, cnt <= 0, go to DELAY.
  - DELAY, same dir held: if cnt == DAS_DELAY-2, pulse, cnt <= 0, go to REPEAT; else cnt <= cnt+1.
  - REPEAT, same dir held: if cnt == DAS_RATE-1, pulse, cnt <= 0; else cnt <= cnt+1.
  - Releasing one of L+R held together: the remaining direction pulses immediately and enters DELAY.
- Down FSM:
  - Same states and rules, driven by cur[5] only, no dir register; outputs soft_drop.
  - Independent of the horizontal FSM. Simultaneous move and soft_drop pulses are allowed.
  - Up and Down together: both act independently.
- Counters never exceed their terminal values, so no wrap-around.

Optional Feature:
- Macro: TETRIS_BUTTON_DEBOUNCE_EN.
- Defined:
  - An extra raw register holds the previous raw strobe sample.
  - Each cur bit updates only when buttons[i] equals that raw register bit, i.e. two consecutive identical strobes.
  - Adds one strobe of latency. A single-strobe glitch produces no pulse.
- Undefined: cur = buttons on each strobe; no raw register.

Test Plan:
- Reset, then press A on strobe 1 and hold for 5 strobes -> rotate_cw exactly once, 1 clk after strobe 1; no other outputs.
- Hold Left for strobes 1..30 (DAS_DELAY=16, DAS_RATE=6) -> move_left after strobes 1, 16, 22, 28 only; release at strobe 31 -> no further pulses.
- Hold Left for strobes 1..5, then Left+Right for 6..10, then Right only from 11 -> move_left at strobe 1; nothing for 6..10; move_right at strobe 11, next at 26.
- Hold Down and Right from strobe 1; press Up on strobe 3 -> soft_drop and move_right both pulse at strobe 1; hard_drop at strobe 3 only.
- Hold Right, assert reset for 3 cycles mid-REPEAT with Right still held -> all outputs 0 during reset; move_right on the first strobe after reset, next repeat 15 strobes later.
- Debounce defined: Start high on strobe 4 only -> no pause_toggle. Start high for strobes 6..7 -> pause_toggle after strobe 7. Debounce undefined: the strobe-4 glitch pulses.
